// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential floating-point mul/div engine.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ITER,
    ST_NORM_RND,
    ST_DONE
  } state_t;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_DIV    = 1'b1;
  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Bit positions inside the 3-bit flags word {dz, of, uf}.
  localparam int FLAG_UF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_DZ = 2;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fpu_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Rounds a normalised significand (leading 1 at bit MAN_W) and packs it,
// saturating to {s, all-ones, 0} on overflow and flushing to {s, 0, 0} on
// underflow. Purely combinational so the add/sub path can share it.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic                     sign,
  input  logic [MAN_W:0]           mant,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXP_W+1:0]  exp_in,
  input  logic                     rnd,
  output logic [W-1:0]             word,
  output logic                     of,
  output logic                     uf
);

  localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W + 2)'(fpu_exp_max(EXP_W));

  logic                    inc;
  logic [MAN_W+1:0]        sum;
  logic [MAN_W-1:0]        frac;
  logic signed [EXP_W+1:0] exp_fin;

  // Round-to-nearest-even increment, carry renormalisation and range clamp.
  always_comb begin
    inc     = (rnd == RND_RNE) && guard && (sticky || mant[0]);
    sum     = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, inc};
    frac    = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_fin = exp_in + $signed({{(EXP_W + 1){1'b0}}, sum[MAN_W+1]});
    of      = 1'b0;
    uf      = 1'b0;
    word    = {sign, exp_fin[EXP_W-1:0], frac};
    if (!exp_fin[EXP_W+1] && (exp_fin >= EXP_MAX_S)) begin
      of   = 1'b1;
      word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_fin[EXP_W+1] || (exp_fin == '0)) begin
      uf   = 1'b1;
      word = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end
  end

endmodule

// File: rtl/fpu_muldiv_seq.sv
// Sequential floating-point multiplier/divider, one quotient/product bit per
// cycle, with valid/ready handshakes on both sides.
//
// state       | meaning
// ST_IDLE     | ready for operands, latches x/y/op/rnd on accept
// ST_UNPACK   | split fields, form exponent, detect zero/dz bypass
// ST_ITER     | MAN_W+3 shift-add (mul) or restoring-divide (div) steps
// ST_NORM_RND | 1-position normalise, round, pack, register result
// ST_DONE     | result/flags held until out_ready
module fpu_muldiv_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic         rnd,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  localparam int P  = MAN_W + 1;
  localparam int QW = MAN_W + 3;
  localparam int PW = 2 * P + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);
  localparam logic signed [EW-1:0] BIAS_S = EW'(fpu_bias(EXP_W));
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);

  state_t state, state_n;

  logic [W-1:0]         x_r, y_r;
  logic                 op_r, rnd_r, sign_r, byp_r;
  logic signed [EW-1:0] exp_r;
  logic [P-1:0]         sx, sy;
  logic [PW-1:0]        acc;
  logic [QW-1:0]        qm;
  logic [P:0]           rem;
  logic [CW-1:0]        cnt;
  logic [W-1:0]         byp_word;
  logic [2:0]           byp_flags;

  logic [EXP_W-1:0]     ex, ey;
  logic                 x_zero, y_zero, byp_dz, byp_zero;
  logic signed [EW-1:0] exp_mul, exp_div;
  logic [W-1:0]         byp_word_n;
  logic [2:0]           byp_flags_n;

  logic [P-1:0]         n_mant;
  logic                 n_guard, n_sticky;
  logic signed [EW-1:0] n_exp;
  logic [W-1:0]         rp_word;
  logic                 rp_of, rp_uf;
  logic [2:0]           rp_flags;

  // Field decode, exponent arithmetic and special-case classification.
  always_comb begin
    ex          = x_r[W-2:MAN_W];
    ey          = y_r[W-2:MAN_W];
    x_zero      = (ex == '0);
    y_zero      = (ey == '0);
    exp_mul     = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_S;
    exp_div     = $signed({2'b00, ex}) - $signed({2'b00, ey}) + BIAS_S;
    byp_dz      = (op_r == OP_DIV) && y_zero;
    byp_zero    = !byp_dz && (x_zero || ((op_r == OP_MUL) && y_zero));
    byp_flags_n = '0;
    byp_word_n  = {x_r[W-1] ^ y_r[W-1], {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    if (byp_dz) begin
      byp_flags_n[FLAG_DZ] = 1'b1;
      byp_word_n = {x_r[W-1] ^ y_r[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ST_UNPACK;
      end
      // Special cases skip the iteration but still go through the result
      // register stage, so they land in DONE two cycles after accept.
      ST_UNPACK:   state_n = (byp_dz || byp_zero) ? ST_NORM_RND : ST_ITER;
      ST_ITER:     if (cnt == '0) state_n = ST_NORM_RND;
      ST_NORM_RND: state_n = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = ST_IDLE;
      end
      default:     state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Normalise the raw product/quotient by at most one position.
  always_comb begin
    if (op_r == OP_MUL) begin
      if (acc[PW-1]) begin
        n_mant   = acc[PW-1 -: P];
        n_guard  = acc[PW-1-P];
        n_sticky = |acc[PW-2-P:0];
        n_exp    = exp_r + ONE_S;
      end else begin
        n_mant   = acc[PW-2 -: P];
        n_guard  = acc[PW-2-P];
        n_sticky = |acc[PW-3-P:0];
        n_exp    = exp_r;
      end
    end else begin
      if (qm[QW-1]) begin
        n_mant   = qm[QW-1:2];
        n_guard  = qm[1];
        n_sticky = qm[0] || (rem != '0);
        n_exp    = exp_r;
      end else begin
        n_mant   = qm[QW-2:1];
        n_guard  = qm[0];
        n_sticky = (rem != '0);
        n_exp    = exp_r - ONE_S;
      end
    end
  end

  fpu_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (sign_r),
    .mant   (n_mant),
    .guard  (n_guard),
    .sticky (n_sticky),
    .exp_in (n_exp),
    .rnd    (rnd_r),
    .word   (rp_word),
    .of     (rp_of),
    .uf     (rp_uf)
  );

  // Assemble the rounded-path flags word.
  always_comb begin
    rp_flags          = '0;
    rp_flags[FLAG_OF] = rp_of;
    rp_flags[FLAG_UF] = rp_uf;
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r       <= '0;
      y_r       <= '0;
      op_r      <= OP_MUL;
      rnd_r     <= RND_TRUNC;
      sign_r    <= 1'b0;
      byp_r     <= 1'b0;
      exp_r     <= '0;
      sx        <= '0;
      sy        <= '0;
      acc       <= '0;
      qm        <= '0;
      rem       <= '0;
      cnt       <= '0;
      byp_word  <= '0;
      byp_flags <= '0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_r   <= x;
            y_r   <= y;
            op_r  <= op;
            rnd_r <= rnd;
          end
        end
        ST_UNPACK: begin
          sign_r    <= x_r[W-1] ^ y_r[W-1];
          exp_r     <= (op_r == OP_DIV) ? exp_div : exp_mul;
          sx        <= {1'b1, x_r[MAN_W-1:0]};
          sy        <= {1'b1, y_r[MAN_W-1:0]};
          acc       <= '0;
          // Multiplier is padded with two zero LSBs so both ops take QW steps;
          // the product then sits two bits up in acc.
          qm        <= (op_r == OP_MUL) ? {1'b1, y_r[MAN_W-1:0], 2'b00} : '0;
          rem       <= {1'b0, 1'b1, x_r[MAN_W-1:0]};
          cnt       <= CW'(QW - 1);
          byp_r     <= byp_dz || byp_zero;
          byp_word  <= byp_word_n;
          byp_flags <= byp_flags_n;
        end
        ST_ITER: begin
          cnt <= cnt - 1'b1;
          if (op_r == OP_MUL) begin
            acc <= (acc << 1) + (qm[QW-1] ? {{(PW - P){1'b0}}, sx} : '0);
            qm  <= qm << 1;
          end else if (rem >= {1'b0, sy}) begin
            rem <= (rem - {1'b0, sy}) << 1;
            qm  <= {qm[QW-2:0], 1'b1};
          end else begin
            rem <= rem << 1;
            qm  <= {qm[QW-2:0], 1'b0};
          end
        end
        ST_NORM_RND: begin
          result <= byp_r ? byp_word : rp_word;
          flags  <= byp_r ? byp_flags : rp_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_muldiv_seq.sv
// Directed bench: half-precision instance plus a single-precision instance.
module tb_fpu_muldiv_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        in_valid_a = 0, op_a = 0, rnd_a = 0, out_ready_a = 0;
  logic        in_ready_a, out_valid_a;
  logic [15:0] x_a = '0, y_a = '0, result_a;
  logic [2:0]  flags_a;

  logic        in_valid_b = 0, op_b = 0, rnd_b = 0, out_ready_b = 0;
  logic        in_ready_b, out_valid_b;
  logic [31:0] x_b = '0, y_b = '0, result_b;
  logic [2:0]  flags_b;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fpu_muldiv_seq dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .op(op_a), .rnd(rnd_a), .x(x_a), .y(y_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .result(result_a), .flags(flags_a)
  );

  fpu_muldiv_seq #(.EXP_W(8), .MAN_W(23)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op(op_b), .rnd(rnd_b), .x(x_b), .y(y_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .result(result_b), .flags(flags_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic o, input logic r, input logic [15:0] xv,
                       input logic [15:0] yv, input logic [15:0] exp_res,
                       input logic [2:0] exp_flg, input int exp_lat,
                       input string tag, input int hold);
    int lat;
    chk({tag, "_in_ready_idle"}, in_ready_a, 1);
    in_valid_a = 1; op_a = o; rnd_a = r; x_a = xv; y_a = yv;
    tick();
    in_valid_a = 0; op_a = ~o; rnd_a = ~r; x_a = 16'hFFFF; y_a = 16'h3C00;
    chk({tag, "_in_ready_busy"}, in_ready_a, 0);
    lat = 0;
    while (!out_valid_a && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result_a, exp_res);
    chk({tag, "_flags"}, flags_a, exp_flg);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid_a, 1);
      chk({tag, "_hold_result"}, result_a, exp_res);
      chk({tag, "_hold_flags"}, flags_a, exp_flg);
      chk({tag, "_hold_in_ready"}, in_ready_a, 0);
    end
    chk({tag, "_in_ready_done"}, in_ready_a, 0);
    out_ready_a = 1;
    tick();
    out_ready_a = 0;
    chk({tag, "_valid_drop"}, out_valid_a, 0);
    chk({tag, "_in_ready_after"}, in_ready_a, 1);
  endtask

  task automatic run_b(input logic o, input logic r, input logic [31:0] xv,
                       input logic [31:0] yv, input logic [31:0] exp_res,
                       input int exp_lat, input string tag);
    int lat;
    in_valid_b = 1; op_b = o; rnd_b = r; x_b = xv; y_b = yv;
    tick();
    in_valid_b = 0; x_b = '0; y_b = '0;
    lat = 0;
    while (!out_valid_b && lat < 80) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result_b, exp_res);
    chk({tag, "_flags"}, flags_b, 3'b000);
    out_ready_b = 1;
    tick();
    out_ready_b = 0;
    chk({tag, "_in_ready_after"}, in_ready_b, 1);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    reset = 0;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_result", result_a, 16'h0000);
    chk("rst_flags", flags_a, 3'b000);
    chk("rst_b_result", result_b, 32'h0);

    run_a(0, 0, 16'h4F00, 16'h0B80, 16'h1E90, 3'b000, 15, "mul_4f00_0b80", 0);
    run_a(0, 0, 16'h50BB, 16'h50BB, 16'h6598, 3'b000, 15, "mul_50bb_sq", 0);
    run_a(0, 0, 16'hD98D, 16'h4F08, 16'hECE0, 3'b000, 15, "mul_d98d_4f08", 0);
    run_a(1, 0, 16'hD98D, 16'h4F08, 16'hC650, 3'b000, 15, "div_d98d_4f08", 0);
    run_a(1, 0, 16'h418D, 16'hB308, 16'hCA50, 3'b000, 15, "div_418d_b308", 0);
    run_a(0, 0, 16'h3E00, 16'h3C01, 16'h3E01, 3'b000, 15, "mul_tie_trunc", 0);
    run_a(0, 1, 16'h3E00, 16'h3C01, 16'h3E02, 3'b000, 15, "mul_tie_rne_up", 0);
    run_a(0, 1, 16'h3E00, 16'h3C03, 16'h3E04, 3'b000, 15, "mul_tie_rne_even", 0);
    run_a(1, 0, 16'h118D, 16'hEF08, 16'h8000, 3'b001, 15, "div_underflow", 0);
    run_a(0, 0, 16'h7800, 16'h7800, 16'h7C00, 3'b010, 15, "mul_overflow", 0);
    run_a(1, 0, 16'h3C00, 16'h0000, 16'h7C00, 3'b100, 2, "div_by_zero", 0);
    run_a(0, 0, 16'hBC00, 16'h0000, 16'h8000, 3'b000, 2, "mul_by_zero", 0);
    run_a(0, 0, 16'h4F00, 16'h0B80, 16'h1E90, 3'b000, 15, "stall", 5);

    in_valid_a = 1; op_a = 0; rnd_a = 0; x_a = 16'h4F00; y_a = 16'h0B80;
    tick();
    in_valid_a = 0;
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midreset_in_ready", in_ready_a, 1);
    chk("midreset_out_valid", out_valid_a, 0);
    chk("midreset_result", result_a, 16'h0000);
    chk("midreset_flags", flags_a, 3'b000);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid_a) seen = 1;
    end
    chk("midreset_no_output", seen, 0);
    run_a(1, 0, 16'hD98D, 16'h4F08, 16'hC650, 3'b000, 15, "after_reset", 0);

    run_b(0, 0, 32'h40400000, 32'h40000000, 32'h40C00000, 28, "sp_mul");
    run_b(1, 1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "sp_div_rne");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
